// File: rtl/watch_time_reporter.sv
// watch_time_reporter: snapshots hour/min/sec and streams "HH:MM:SS[\r\n]" as ASCII bytes to uart_tx.
module watch_time_reporter #(
  parameter bit SEND_CRLF   = 1'b1,
  parameter bit AUTO_REPORT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req,
  input  logic [4:0] i_hour,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  input  logic       i_tx_busy,
  input  logic       i_tx_done,
  output logic [7:0] o_tx_data,
  output logic       o_tx_start,
  output logic       o_busy
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;
  localparam logic [3:0] LAST   = SEND_CRLF ? 4'd9 : 4'd7;

  logic [1:0] state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       pend_q, pend_d;
  logic       busy_d, start_d;
  logic [7:0] data_d;
  logic [5:0] prev_sec_q;
  logic [3:0] ht_q, ho_q, mt_q, mo_q, st_q, so_q;
  logic [7:0] frame_byte;
  logic       req_any;

  assign req_any = i_req | (AUTO_REPORT && (i_sec != prev_sec_q));

  // Digits are at most 9 (tens of out-of-range inputs stay below 16), so 0x30+d is a nibble concat.
  always_comb begin
    case (idx_q)
      4'd0:       frame_byte = {4'h3, ht_q};
      4'd1:       frame_byte = {4'h3, ho_q};
      4'd2, 4'd5: frame_byte = 8'h3A;
      4'd3:       frame_byte = {4'h3, mt_q};
      4'd4:       frame_byte = {4'h3, mo_q};
      4'd6:       frame_byte = {4'h3, st_q};
      4'd7:       frame_byte = {4'h3, so_q};
      4'd8:       frame_byte = 8'h0D;
      4'd9:       frame_byte = 8'h0A;
      default:    frame_byte = 8'h00;
    endcase
  end

  // A request arriving with the final i_tx_done is treated as pending and chains straight to LOAD.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q | (i_req && state_q != S_IDLE);
    busy_d  = o_busy;
    start_d = 1'b0;
    data_d  = o_tx_data;
    case (state_q)
      S_IDLE: if (req_any) begin
        state_d = S_LOAD;
        busy_d  = 1'b1;
      end
      S_LOAD: begin
        idx_d   = 4'd0;
        state_d = S_SEND;
      end
      S_SEND: if (!i_tx_busy) begin
        data_d  = frame_byte;
        start_d = 1'b1;
        state_d = S_WAIT;
      end
      default: if (i_tx_done) begin
        if (idx_q != LAST) begin
          idx_d   = idx_q + 4'd1;
          state_d = S_SEND;
        end else if (pend_q || i_req) begin
          state_d = S_LOAD;
          pend_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= 4'd0;
      pend_q     <= 1'b0;
      o_busy     <= 1'b0;
      o_tx_start <= 1'b0;
      o_tx_data  <= 8'h00;
      prev_sec_q <= 6'd0;
      ht_q       <= 4'd0;
      ho_q       <= 4'd0;
      mt_q       <= 4'd0;
      mo_q       <= 4'd0;
      st_q       <= 4'd0;
      so_q       <= 4'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      o_busy     <= busy_d;
      o_tx_start <= start_d;
      o_tx_data  <= data_d;
      prev_sec_q <= i_sec;
      if (state_q == S_LOAD) begin
        ht_q <= 4'(i_hour / 5'd10);
        ho_q <= 4'(i_hour % 5'd10);
        mt_q <= 4'(i_min / 6'd10);
        mo_q <= 4'(i_min % 6'd10);
        st_q <= 4'(i_sec / 6'd10);
        so_q <= 4'(i_sec % 6'd10);
      end
    end
  end
endmodule

// File: tb/tb_watch_time_reporter.sv
// tb_watch_time_reporter: directed tests over three parameterisations with a simple uart_tx responder.
module tb_watch_time_reporter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst;
  logic       req[3];
  logic [4:0] hours[3];
  logic [5:0] mins[3];
  logic [5:0] secs[3];
  logic       hold[3], mbusy[3], done[3];
  logic [7:0] data[3];
  logic       start[3], busy[3];
  logic [7:0] cap[3][128];
  int         n[3] = '{0, 0, 0};
  int         t[3];
  int         tests = 0, fails = 0;

  watch_time_reporter #(.SEND_CRLF(1'b1), .AUTO_REPORT(1'b0)) u0 (
    .clk(clk), .rst(rst), .i_req(req[0]), .i_hour(hours[0]), .i_min(mins[0]), .i_sec(secs[0]),
    .i_tx_busy(hold[0] | mbusy[0]), .i_tx_done(done[0]),
    .o_tx_data(data[0]), .o_tx_start(start[0]), .o_busy(busy[0]));
  watch_time_reporter #(.SEND_CRLF(1'b0), .AUTO_REPORT(1'b0)) u1 (
    .clk(clk), .rst(rst), .i_req(req[1]), .i_hour(hours[1]), .i_min(mins[1]), .i_sec(secs[1]),
    .i_tx_busy(hold[1] | mbusy[1]), .i_tx_done(done[1]),
    .o_tx_data(data[1]), .o_tx_start(start[1]), .o_busy(busy[1]));
  watch_time_reporter #(.SEND_CRLF(1'b1), .AUTO_REPORT(1'b1)) u2 (
    .clk(clk), .rst(rst), .i_req(req[2]), .i_hour(hours[2]), .i_min(mins[2]), .i_sec(secs[2]),
    .i_tx_busy(hold[2] | mbusy[2]), .i_tx_done(done[2]),
    .o_tx_data(data[2]), .o_tx_start(start[2]), .o_busy(busy[2]));

  // uart_tx stand-in: records each launched byte, stays busy 3 cycles, then pulses done.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst) begin
        mbusy[k] <= 1'b0;
        done[k]  <= 1'b0;
        t[k]     <= 0;
      end else begin
        done[k] <= 1'b0;
        if (start[k]) begin
          if (n[k] < 128) cap[k][n[k]] <= data[k];
          n[k]     <= n[k] + 1;
          t[k]     <= 3;
          mbusy[k] <= 1'b1;
        end else if (t[k] == 1) begin
          t[k]     <= 0;
          mbusy[k] <= 1'b0;
          done[k]  <= 1'b1;
        end else if (t[k] > 1) begin
          t[k] <= t[k] - 1;
        end
      end
    end
  end

  function automatic logic [7:0] fb(input int h, input int m, input int s, input int i);
    int v;
    case (i)
      0: v = 48 + h / 10;
      1: v = 48 + h % 10;
      2, 5: v = 58;
      3: v = 48 + m / 10;
      4: v = 48 + m % 10;
      6: v = 48 + s / 10;
      7: v = 48 + s % 10;
      8: v = 13;
      default: v = 10;
    endcase
    return v[7:0];
  endfunction

  task automatic set_time(input int k, input int h, input int m, input int s);
    hours[k] = 5'(h);
    mins[k]  = 6'(m);
    secs[k]  = 6'(s);
  endtask

  task automatic pulse(input int k);
    @(negedge clk) req[k] = 1'b1;
    @(negedge clk) req[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    for (int i = 0; i < 3000 && busy[k]; i++) @(negedge clk);
  endtask

  task automatic wait_bytes(input int k, input int target);
    for (int i = 0; i < 3000 && n[k] < target; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({data[k], start[k], busy[k]} !== 10'd0) begin
        fails++;
        $display("FAIL reset_outputs[%0d] got %h exp 000", k, {data[k], start[k], busy[k]});
      end
    end
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int base;
    set_time(0, 12, 34, 56);
    base = n[0];
    pulse(0);
    tests++;
    if (busy[0] !== 1'b1 || start[0] !== 1'b0) begin
      fails++;
      $display("FAIL basic_accept got busy=%b start=%b exp busy=1 start=0", busy[0], start[0]);
    end
    @(negedge clk);
    tests++;
    if (start[0] !== 1'b0) begin
      fails++;
      $display("FAIL basic_load_cycle got start=%b exp 0", start[0]);
    end
    @(negedge clk);
    tests++;
    if (start[0] !== 1'b1 || data[0] !== 8'h31) begin
      fails++;
      $display("FAIL basic_latency got start=%b data=%h exp start=1 data=31", start[0], data[0]);
    end
    wait_idle(0);
    repeat (20) @(negedge clk);
    tests++;
    if (busy[0] !== 1'b0 || n[0] - base !== 10) begin
      fails++;
      $display("FAIL basic_count got busy=%b bytes=%0d exp busy=0 bytes=10", busy[0], n[0] - base);
    end
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (cap[0][base+i] !== fb(12, 34, 56, i)) begin
        fails++;
        $display("FAIL basic_byte%0d got %h exp %h", i, cap[0][base+i], fb(12, 34, 56, i));
      end
    end
  endtask

  task automatic test_no_crlf;
    int base;
    int at_fall;
    set_time(1, 0, 0, 0);
    base = n[1];
    at_fall = -1;
    pulse(1);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy[1]) begin
        at_fall = n[1] - base;
        break;
      end
      tests++;
      if (n[1] - base == 8 && t[1] > 1 && busy[1] !== 1'b1) begin
        fails++;
        $display("FAIL nocrlf_busy_early got busy=%b exp 1", busy[1]);
      end
    end
    tests++;
    if (at_fall !== 8) begin
      fails++;
      $display("FAIL nocrlf_busy_fall got bytes=%0d exp 8", at_fall);
    end
    repeat (30) @(negedge clk);
    tests++;
    if (n[1] - base !== 8) begin
      fails++;
      $display("FAIL nocrlf_count got %0d exp 8", n[1] - base);
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (cap[1][base+i] !== fb(0, 0, 0, i)) begin
        fails++;
        $display("FAIL nocrlf_byte%0d got %h exp %h", i, cap[1][base+i], fb(0, 0, 0, i));
      end
    end
  endtask

  task automatic test_busy_hold;
    int base;
    set_time(0, 9, 8, 7);
    hold[0] = 1'b1;
    base = n[0];
    pulse(0);
    repeat (50) @(negedge clk);
    tests++;
    if (n[0] !== base || busy[0] !== 1'b1) begin
      fails++;
      $display("FAIL hold_no_start got starts=%0d busy=%b exp starts=0 busy=1", n[0] - base, busy[0]);
    end
    hold[0] = 1'b0;
    wait_idle(0);
    repeat (20) @(negedge clk);
    tests++;
    if (n[0] - base !== 10) begin
      fails++;
      $display("FAIL hold_count got %0d exp 10", n[0] - base);
    end
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (cap[0][base+i] !== fb(9, 8, 7, i)) begin
        fails++;
        $display("FAIL hold_byte%0d got %h exp %h", i, cap[0][base+i], fb(9, 8, 7, i));
      end
    end
  endtask

  task automatic test_snapshot_pending;
    int base;
    set_time(0, 10, 20, 5);
    base = n[0];
    pulse(0);
    wait_bytes(0, base + 3);
    secs[0] = 6'd6;
    pulse(0);
    repeat (2) @(negedge clk);
    pulse(0);
    wait_idle(0);
    repeat (40) @(negedge clk);
    tests++;
    if (n[0] - base !== 20) begin
      fails++;
      $display("FAIL pending_count got %0d exp 20", n[0] - base);
    end
    for (int i = 0; i < 20; i++) begin
      tests++;
      if (cap[0][base+i] !== fb(10, 20, i < 10 ? 5 : 6, i % 10)) begin
        fails++;
        $display("FAIL pending_byte%0d got %h exp %h", i, cap[0][base+i], fb(10, 20, i < 10 ? 5 : 6, i % 10));
      end
    end
  endtask

  task automatic test_final_done_req;
    int base;
    set_time(1, 1, 2, 3);
    base = n[1];
    pulse(1);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (done[1] && n[1] - base == 8) begin
        set_time(1, 4, 5, 6);
        req[1] = 1'b1;
        @(negedge clk) req[1] = 1'b0;
        break;
      end
    end
    wait_idle(1);
    repeat (30) @(negedge clk);
    tests++;
    if (n[1] - base !== 16) begin
      fails++;
      $display("FAIL lastdone_count got %0d exp 16", n[1] - base);
    end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (cap[1][base+i] !== (i < 8 ? fb(1, 2, 3, i) : fb(4, 5, 6, i - 8))) begin
        fails++;
        $display("FAIL lastdone_byte%0d got %h", i, cap[1][base+i]);
      end
    end
  endtask

  task automatic test_auto;
    int base;
    base = n[2];
    @(negedge clk) set_time(2, 23, 59, 59);
    repeat (3) @(negedge clk);
    tests++;
    if (busy[2] !== 1'b1) begin
      fails++;
      $display("FAIL auto_trigger got busy=%b exp 1", busy[2]);
    end
    wait_idle(2);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (cap[2][base+i] !== fb(23, 59, 59, i)) begin
        fails++;
        $display("FAIL auto_first_byte%0d got %h exp %h", i, cap[2][base+i], fb(23, 59, 59, i));
      end
    end
    base = n[2];
    set_time(2, 0, 0, 0);
    repeat (3) @(negedge clk);
    wait_idle(2);
    repeat (40) @(negedge clk);
    tests++;
    if (n[2] - base !== 10) begin
      fails++;
      $display("FAIL auto_count got %0d exp 10", n[2] - base);
    end
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (cap[2][base+i] !== fb(0, 0, 0, i)) begin
        fails++;
        $display("FAIL auto_byte%0d got %h exp %h", i, cap[2][base+i], fb(0, 0, 0, i));
      end
    end
  endtask

  task automatic test_reset_mid;
    int base;
    set_time(0, 17, 45, 30);
    base = n[0];
    pulse(0);
    wait_bytes(0, base + 5);
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({data[0], start[0], busy[0]} !== 10'd0) begin
      fails++;
      $display("FAIL midreset_outputs got %h exp 000", {data[0], start[0], busy[0]});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    tests++;
    if (n[0] - base !== 5 || busy[0] !== 1'b0) begin
      fails++;
      $display("FAIL midreset_no_resume got bytes=%0d busy=%b exp bytes=5 busy=0", n[0] - base, busy[0]);
    end
    base = n[0];
    pulse(0);
    wait_idle(0);
    repeat (20) @(negedge clk);
    tests++;
    if (n[0] - base !== 10) begin
      fails++;
      $display("FAIL midreset_count got %0d exp 10", n[0] - base);
    end
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (cap[0][base+i] !== fb(17, 45, 30, i)) begin
        fails++;
        $display("FAIL midreset_byte%0d got %h exp %h", i, cap[0][base+i], fb(17, 45, 30, i));
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req[k]  = 1'b0;
      hold[k] = 1'b0;
      set_time(k, 0, 0, 0);
    end
    repeat (2) @(negedge clk);
    test_reset;
    test_basic;
    test_no_crlf;
    test_busy_hold;
    test_snapshot_pending;
    test_final_done_req;
    test_auto;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
